inv_mix_columns_iter: RTL and testbench

- Iterative AES InvMixColumns engine for the decryption datapath, the inverse of the MixColumn transform.
- Accepts a full 128-bit state over a valid/ready handshake and transforms it a configurable number of columns per cycle.
- Presents the result over a valid/ready handshake with backpressure.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the inverse cipher round.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/inv_mix_column.sv | 18 +
 rtl/inv_mix_columns_iter.sv | 89 ++++++++
 tb/tb_inv_mix_columns_iter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and the iterative InvMixColumns FSM encoding.
package aes_pkg;

  localparam logic [7:0] GF_POLY_RED = 8'h1B;

  localparam logic [7:0] GF_COEF_09 = 8'h09;
  localparam logic [7:0] GF_COEF_0B = 8'h0B;
  localparam logic [7:0] GF_COEF_0D = 8'h0D;
  localparam logic [7:0] GF_COEF_0E = 8'h0E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } imc_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY_RED : 8'h00);
  endfunction

  // Only the four InvMixColumns coefficients are supported; built from x2/x4/x8.
  function automatic logic [7:0] gf_mul_inv_coef(input logic [7:0] b, input logic [7:0] coef);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] r;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    case (coef)
      GF_COEF_09: r = x8 ^ b;
      GF_COEF_0B: r = x8 ^ x2 ^ b;
      GF_COEF_0D: r = x8 ^ x4 ^ b;
      GF_COEF_0E: r = x8 ^ x4 ^ x2;
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

  // Row r of the matrix is [0e 0b 0d 09] rotated right by r.
  function automatic logic [7:0] inv_coef(input int r, input int j);
    logic [1:0] sel;
    logic [7:0] c;
    sel = 2'(j - r);
    case (sel)
      2'd0:    c = GF_COEF_0E;
      2'd1:    c = GF_COEF_0B;
      2'd2:    c = GF_COEF_0D;
      default: c = GF_COEF_09;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumn of one 32-bit column, row 0 in the MSB byte.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        col_o[31-8*r -: 8] = col_o[31-8*r -: 8] ^ gf_mul_inv_coef(col_i[31-8*j -: 8], inv_coef(r, j));
      end
    end
  end

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: loads a state, rewrites COLS_PER_CYCLE columns
// per cycle in place, then holds the result until the consumer takes it.
module inv_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [127:0] In_State,
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [127:0] Out_State,
  output logic         Busy
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : gBadCols
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  imc_state_e   state_q, state_d;
  logic [1:0]   colCnt_q, colCnt_d;
  logic [127:0] stateReg_q, stateReg_d;
  logic         lastGroup;

  logic [1:0]  colIdx [COLS_PER_CYCLE];
  logic [31:0] colIn  [COLS_PER_CYCLE];
  logic [31:0] colOut [COLS_PER_CYCLE];

  // Column c lives at bit offset (3-c)*32, which is {~c, 5'b0} for a 2-bit c.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : gCol
    assign colIdx[g] = colCnt_q + 2'(g);
    assign colIn[g]  = stateReg_q[{~colIdx[g], 5'b0} +: 32];
    inv_mix_column uCol (
      .col_i(colIn[g]),
      .col_o(colOut[g])
    );
  end

  assign lastGroup = ({1'b0, colCnt_q} + STEP) == 3'd4;

  always_comb begin
    state_d    = state_q;
    colCnt_d   = colCnt_q;
    stateReg_d = stateReg_q;
    case (state_q)
      ST_IDLE: begin
        if (In_Valid) begin
          stateReg_d = In_State;
          colCnt_d   = 2'd0;
          state_d    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
          stateReg_d[{~colIdx[g], 5'b0} +: 32] = colOut[g];
        end
        colCnt_d = colCnt_q + STEP[1:0];
        if (lastGroup) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (Out_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      colCnt_q   <= 2'd0;
      stateReg_q <= '0;
    end else begin
      state_q    <= state_d;
      colCnt_q   <= colCnt_d;
      stateReg_q <= stateReg_d;
    end
  end

  assign In_Ready  = (state_q == ST_IDLE);
  assign Out_Valid = (state_q == ST_DONE);
  assign Busy      = (state_q != ST_IDLE);
  assign Out_State = stateReg_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed and round-trip bench for inv_mix_columns_iter at 1, 2 and 4 columns per cycle.
module tb_inv_mix_columns_iter;

  typedef struct {
    logic [31:0] colIn;
    logic [31:0] colExp;
  } colVec_t;

  typedef struct {
    int           k;
    logic [127:0] stIn;
    logic [127:0] stExp;
    int           lat;
  } stVec_t;

  logic         clk;
  logic         rstN;
  logic         inValid  [3];
  logic         inReady  [3];
  logic [127:0] inState  [3];
  logic         outValid [3];
  logic         outReady [3];
  logic [127:0] outState [3];
  logic         busy     [3];
  logic [31:0]  colIn;
  logic [31:0]  colOut;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] FULL_IN  = 128'h5de070bb_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] FULL_EXP = 128'h6347a2f0_f20a225c_01010101_2d26314c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u1 (
    .Clk(clk), .Rst_n(rstN), .In_Valid(inValid[0]), .In_Ready(inReady[0]), .In_State(inState[0]),
    .Out_Valid(outValid[0]), .Out_Ready(outReady[0]), .Out_State(outState[0]), .Busy(busy[0]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u2 (
    .Clk(clk), .Rst_n(rstN), .In_Valid(inValid[1]), .In_Ready(inReady[1]), .In_State(inState[1]),
    .Out_Valid(outValid[1]), .Out_Ready(outReady[1]), .Out_State(outState[1]), .Busy(busy[1]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u4 (
    .Clk(clk), .Rst_n(rstN), .In_Valid(inValid[2]), .In_Ready(inReady[2]), .In_State(inState[2]),
    .Out_Valid(outValid[2]), .Out_Ready(outReady[2]), .Out_State(outState[2]), .Busy(busy[2]));

  inv_mix_column uColumn (.col_i(colIn), .col_o(colOut));

  // Forward MixColumns reference, used to produce inputs whose inverse is known.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ 8'h1B) : {b[6:0], 1'b0};
  endfunction

  function automatic logic [31:0] mixCol(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mixState(input logic [127:0] s);
    return {mixCol(s[127:96]), mixCol(s[95:64]), mixCol(s[63:32]), mixCol(s[31:0])};
  endfunction

  function automatic logic [127:0] randState();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Runs one transaction on instance k; edges counts the handshake edge as 1.
  task automatic applyStimulus(input int k, input logic [127:0] st, input bit hold,
                               output logic [127:0] res, output int edges, output bit ok);
    @(negedge clk);
    inState[k]  = st;
    inValid[k]  = 1'b1;
    outReady[k] = !hold;
    ok    = 1'b1;
    edges = 0;
    res   = '0;
    for (int i = 0; i < 20 && !inReady[k]; i++) @(negedge clk);
    if (!inReady[k]) begin
      ok = 1'b0;
      inValid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    inValid[k] = 1'b0;
    while (!outValid[k] && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    res = outState[k];
    if (!outValid[k]) begin
      ok = 1'b0;
      return;
    end
    if (!hold) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  colVec_t      colVecs [6];
  stVec_t       stVecs  [3];
  logic [127:0] res;
  logic [127:0] orig;
  int           edges;
  bit           ok;
  logic [127:0] b2bOrig [8];
  int           inIdx, outIdx, cyc, lastOut;

  initial begin
    rstN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      inValid[k]  = 1'b0;
      inState[k]  = '0;
      outReady[k] = 1'b0;
    end
    colIn = '0;

    colVecs[0] = '{32'h5de070bb, 32'h6347a2f0};
    colVecs[1] = '{32'h9fdc589d, 32'hf20a225c};
    colVecs[2] = '{32'hd5d5d7d6, 32'hd4d4d4d5};
    colVecs[3] = '{32'h4d7ebdf8, 32'h2d26314c};
    colVecs[4] = '{32'h01010101, 32'h01010101};
    colVecs[5] = '{32'hc6c6c6c6, 32'hc6c6c6c6};
    stVecs[0]  = '{0, FULL_IN, FULL_EXP, 5};
    stVecs[1]  = '{1, FULL_IN, FULL_EXP, 3};
    stVecs[2]  = '{2, FULL_IN, FULL_EXP, 2};

    for (int i = 0; i < 6; i++) begin
      colIn = colVecs[i].colIn;
      #1;
      checkOutput($sformatf("col%0d", i), colOut, colVecs[i].colExp);
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rst_inready%0d", k), inReady[k], 1);
      checkOutput($sformatf("rst_outvalid%0d", k), outValid[k], 0);
      checkOutput($sformatf("rst_busy%0d", k), busy[k], 0);
      checkOutput($sformatf("rst_outstate%0d", k), outState[k], 0);
    end
    rstN = 1'b1;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(stVecs[i].k, stVecs[i].stIn, 1'b0, res, edges, ok);
      checkOutput($sformatf("full_done%0d", i), ok, 1);
      checkOutput($sformatf("full_state%0d", i), res, stVecs[i].stExp);
      checkOutput($sformatf("full_latency%0d", i), edges, stVecs[i].lat);
    end

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < ((k == 0) ? 1000 : 100); n++) begin
        orig = randState();
        applyStimulus(k, mixState(orig), 1'b0, res, edges, ok);
        checkOutput($sformatf("rt_done%0d", k), ok, 1);
        checkOutput($sformatf("rt_state%0d", k), res, orig);
      end
    end

    applyStimulus(0, FULL_IN, 1'b1, res, edges, ok);
    checkOutput("bp_done", ok, 1);
    for (int c = 0; c < 10; c++) begin
      inState[0] = randState();
      inValid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_state", outState[0], FULL_EXP);
      checkOutput("bp_outvalid", outValid[0], 1);
      checkOutput("bp_inready", inReady[0], 0);
    end
    inValid[0]  = 1'b0;
    outReady[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_release_outvalid", outValid[0], 0);
    checkOutput("bp_release_inready", inReady[0], 1);

    inState[0]  = FULL_IN;
    inValid[0]  = 1'b1;
    outReady[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    inValid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst_outvalid", outValid[0], 0);
    checkOutput("midrst_inready", inReady[0], 1);
    checkOutput("midrst_outstate", outState[0], 0);
    checkOutput("midrst_busy", busy[0], 0);
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(0, FULL_IN, 1'b0, res, edges, ok);
    checkOutput("postrst_done", ok, 1);
    checkOutput("postrst_state", res, FULL_EXP);

    for (int i = 0; i < 8; i++) b2bOrig[i] = randState();
    outReady[0] = 1'b1;
    inIdx   = 0;
    outIdx  = 0;
    cyc     = 0;
    lastOut = 0;
    while (outIdx < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (outValid[0]) begin
        checkOutput($sformatf("b2b_state%0d", outIdx), outState[0], b2bOrig[outIdx]);
        if (outIdx > 0) checkOutput("b2b_period", cyc - lastOut, 6);
        lastOut = cyc;
        outIdx++;
      end
      if (inIdx < 8) begin
        inState[0] = mixState(b2bOrig[inIdx]);
        inValid[0] = 1'b1;
        if (inReady[0]) inIdx++;
      end else begin
        inValid[0] = 1'b0;
      end
    end
    inValid[0] = 1'b0;
    checkOutput("b2b_count", outIdx, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
